// File: rtl/pipe_exe_ctrl_pkg.sv
// Shared encodings for the execute-stage pipeline controller:
// operand forwarding selects and the multi-cycle FSM state.
package pipe_exe_ctrl_pkg;

   localparam logic [1:0] FWD_REG  = 2'b00;  // operand from register file
   localparam logic [1:0] FWD_EALU = 2'b01;  // operand from E-stage ALU result
   localparam logic [1:0] FWD_MALU = 2'b10;  // operand from M-stage ALU result
   localparam logic [1:0] FWD_MMEM = 2'b11;  // operand from M-stage memory data

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Forwarding select for one ID-stage source operand. The youngest producer
// (E stage) wins over M; register 0 is never forwarded. An E-stage load
// cannot be forwarded here because its data is not yet available, so the
// load-use stall in the top covers that case.
module pipe_fwd_sel
   import pipe_exe_ctrl_pkg::*;
(
   input  logic [4:0] src,
   input  logic       uses,
   input  logic [4:0] ern,
   input  logic       ewreg,
   input  logic       em2reg,
   input  logic [4:0] mrn,
   input  logic       mwreg,
   input  logic       mm2reg,
   output logic [1:0] fwd
);

   logic ehit;
   logic mhit;

   assign ehit = uses && ewreg && (ern != 5'd0) && (ern == src);
   assign mhit = uses && mwreg && (mrn != 5'd0) && (mrn == src);

   // Priority select: E ALU, then M ALU / M memory, else register file
   always_comb begin
      fwd = FWD_REG;
      if (ehit && !em2reg) begin
         fwd = FWD_EALU;
      end else if (mhit) begin
         fwd = mm2reg ? FWD_MMEM : FWD_MALU;
      end
   end

endmodule

// File: rtl/pipe_exe_ctrl.sv
// Execute-stage pipeline controller: operand forwarding, load-use stall
// and the freeze sequencing for multi-cycle ALU ops that occupy E for
// MULT_LAT cycles.
module pipe_exe_ctrl
   import pipe_exe_ctrl_pkg::*;
#(
   parameter int MULT_LAT = 4
)(
   input  logic       clock,
   input  logic       reset,
   input  logic [4:0] rs,
   input  logic [4:0] rt,
   input  logic       usert,
   input  logic       dmulti,
   input  logic [4:0] ern,
   input  logic       ewreg,
   input  logic       em2reg,
   input  logic [4:0] mrn,
   input  logic       mwreg,
   input  logic       mm2reg,
   input  logic       eflush,
   output logic [1:0] fwda,
   output logic [1:0] fwdb,
   output logic       wpcir,
   output logic       dbubble,
   output logic       efreeze,
   output logic       edone
);

   // The op's last cycle runs unfrozen in IDLE, so BUSY lasts MULT_LAT-1 cycles
   localparam logic [3:0] CNT_INIT = 4'(MULT_LAT - 1);
   localparam bit         MULTI_EN = (MULT_LAT > 1);

   state_t     state;
   logic [3:0] cnt;
   logic       lu;
   logic [1:0] fwda_raw;
   logic [1:0] fwdb_raw;

   pipe_fwd_sel u_fwda (
      .src    (rs),
      .uses   (1'b1),
      .ern    (ern),
      .ewreg  (ewreg),
      .em2reg (em2reg),
      .mrn    (mrn),
      .mwreg  (mwreg),
      .mm2reg (mm2reg),
      .fwd    (fwda_raw)
   );

   pipe_fwd_sel u_fwdb (
      .src    (rt),
      .uses   (usert),
      .ern    (ern),
      .ewreg  (ewreg),
      .em2reg (em2reg),
      .mrn    (mrn),
      .mwreg  (mwreg),
      .mm2reg (mm2reg),
      .fwd    (fwdb_raw)
   );

   assign lu = ewreg && em2reg && (ern != 5'd0) &&
               ((ern == rs) || (usert && (ern == rt)));

   // Multi-cycle sequencer: a pending load-use stall defers entry into BUSY
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (dmulti && !lu && MULTI_EN) begin
                  state <= ST_BUSY;
                  cnt   <= CNT_INIT;
               end
            end
            ST_BUSY: begin
               if (eflush || (cnt == 4'd1)) begin
                  state <= ST_IDLE;
                  cnt   <= 4'd0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
         endcase
      end
   end

   // Control outputs; reset forces the safe free-running values immediately
   always_comb begin
      fwda    = FWD_REG;
      fwdb    = FWD_REG;
      wpcir   = 1'b1;
      dbubble = 1'b0;
      efreeze = 1'b0;
      edone   = 1'b0;
      if (!reset) begin
         fwda = fwda_raw;
         fwdb = fwdb_raw;
         if (state == ST_BUSY) begin
            wpcir   = 1'b0;
            efreeze = !eflush;
            edone   = !eflush && (cnt == 4'd1);
         end else begin
            wpcir   = !lu;
            dbubble = lu;
         end
      end
   end

endmodule

// File: tb/tb_pipe_exe_ctrl.sv
// Directed bench for pipe_exe_ctrl: forwarding priority, load-use stall,
// multi-cycle freeze sequencing, flush and asynchronous reset behaviour.
// A second instance with MULT_LAT=1 shares the stimulus.
module tb_pipe_exe_ctrl;

   logic       clock;
   logic       reset;
   logic [4:0] rs, rt, ern, mrn;
   logic       usert, dmulti, ewreg, em2reg, mwreg, mm2reg, eflush;
   logic [1:0] fwda, fwdb, fwda1, fwdb1;
   logic       wpcir, dbubble, efreeze, edone;
   logic       wpcir1, dbubble1, efreeze1, edone1;

   int checks = 0;
   int errors = 0;

   pipe_exe_ctrl #(.MULT_LAT(4)) u_dut (
      .clock(clock), .reset(reset), .rs(rs), .rt(rt), .usert(usert),
      .dmulti(dmulti), .ern(ern), .ewreg(ewreg), .em2reg(em2reg),
      .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg), .eflush(eflush),
      .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir), .dbubble(dbubble),
      .efreeze(efreeze), .edone(edone)
   );

   pipe_exe_ctrl #(.MULT_LAT(1)) u_dut1 (
      .clock(clock), .reset(reset), .rs(rs), .rt(rt), .usert(usert),
      .dmulti(dmulti), .ern(ern), .ewreg(ewreg), .em2reg(em2reg),
      .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg), .eflush(eflush),
      .fwda(fwda1), .fwdb(fwdb1), .wpcir(wpcir1), .dbubble(dbubble1),
      .efreeze(efreeze1), .edone(edone1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear();
      rs = 5'd0; rt = 5'd0; usert = 1'b0; dmulti = 1'b0;
      ern = 5'd0; ewreg = 1'b0; em2reg = 1'b0;
      mrn = 5'd0; mwreg = 1'b0; mm2reg = 1'b0; eflush = 1'b0;
   endtask

   initial begin
      clear();
      // reset held with inputs that would otherwise forward and stall
      reset = 1'b1;
      rs = 5'd5; rt = 5'd5; usert = 1'b1; ern = 5'd5; ewreg = 1'b1; em2reg = 1'b1;
      mrn = 5'd5; mwreg = 1'b1;
      #2;
      chk2("rst_fwda", fwda, 2'b00);
      chk2("rst_fwdb", fwdb, 2'b00);
      chk1("rst_wpcir", wpcir, 1'b1);
      chk1("rst_dbubble", dbubble, 1'b0);
      chk1("rst_efreeze", efreeze, 1'b0);
      chk1("rst_edone", edone, 1'b0);
      chk1("rst_wpcir_ml1", wpcir1, 1'b1);
      tick();
      chk1("rst_wpcir_edge", wpcir, 1'b1);
      reset = 1'b0;
      clear();
      #1;
      chk1("post_rst_wpcir", wpcir, 1'b1);
      chk1("post_rst_efreeze", efreeze, 1'b0);

      // forwarding priority on rs
      rs = 5'd5; ern = 5'd5; ewreg = 1'b1; em2reg = 1'b0; mrn = 5'd5; mwreg = 1'b1;
      #1;
      chk2("fwda_e_beats_m", fwda, 2'b01);
      chk1("fwda_e_wpcir", wpcir, 1'b1);
      ewreg = 1'b0;
      #1 chk2("fwda_malu", fwda, 2'b10);
      mm2reg = 1'b1;
      #1 chk2("fwda_mmem", fwda, 2'b11);
      rs = 5'd6;
      #1 chk2("fwda_nomatch", fwda, 2'b00);
      rs = 5'd0; mrn = 5'd0;
      #1 chk2("fwda_m_r0", fwda, 2'b00);

      // forwarding on rt gated by usert
      clear();
      rt = 5'd7; usert = 1'b1; ern = 5'd7; ewreg = 1'b1;
      #1 chk2("fwdb_ealu", fwdb, 2'b01);
      usert = 1'b0;
      #1 chk2("fwdb_nouse", fwdb, 2'b00);

      // register 0 load in E: no forward, no stall
      clear();
      ern = 5'd0; ewreg = 1'b1; em2reg = 1'b1; rs = 5'd0;
      #1;
      chk2("r0_fwda", fwda, 2'b00);
      chk1("r0_wpcir", wpcir, 1'b1);
      chk1("r0_dbubble", dbubble, 1'b0);

      // load-use on rt only when usert
      clear();
      rs = 5'd1; rt = 5'd3; usert = 1'b0; ern = 5'd3; ewreg = 1'b1; em2reg = 1'b1;
      #1;
      chk1("lu_nouse_wpcir", wpcir, 1'b1);
      chk1("lu_nouse_dbubble", dbubble, 1'b0);
      chk2("lu_nouse_fwdb", fwdb, 2'b00);
      usert = 1'b1;
      #1;
      chk1("lu_wpcir", wpcir, 1'b0);
      chk1("lu_dbubble", dbubble, 1'b1);
      chk2("lu_fwdb", fwdb, 2'b00);
      tick();
      ern = 5'd0; ewreg = 1'b0; em2reg = 1'b0; mrn = 5'd3; mwreg = 1'b1; mm2reg = 1'b1;
      #1;
      chk1("lu_after_wpcir", wpcir, 1'b1);
      chk1("lu_after_dbubble", dbubble, 1'b0);
      chk2("lu_after_fwdb", fwdb, 2'b11);

      // multi-cycle op blocked by load-use: stall first, BUSY later
      clear();
      dmulti = 1'b1; rs = 5'd4; ern = 5'd4; ewreg = 1'b1; em2reg = 1'b1;
      #1;
      chk1("mlu_wpcir", wpcir, 1'b0);
      chk1("mlu_dbubble", dbubble, 1'b1);
      tick();
      chk1("mlu_still_idle", efreeze, 1'b0);
      ern = 5'd0; ewreg = 1'b0; em2reg = 1'b0;
      #1;
      chk1("mlu_clear_wpcir", wpcir, 1'b1);
      tick();
      dmulti = 1'b0;
      #1;
      chk1("mlu_busy_efreeze", efreeze, 1'b1);
      chk1("mlu_busy_wpcir", wpcir, 1'b0);
      tick();
      tick();
      chk1("mlu_edone", edone, 1'b1);
      tick();
      chk1("mlu_idle_efreeze", efreeze, 1'b0);

      // single multi-cycle op, MULT_LAT=4 vs MULT_LAT=1
      clear();
      dmulti = 1'b1;
      #1;
      chk1("m4_id_efreeze", efreeze, 1'b0);
      chk1("m4_id_wpcir", wpcir, 1'b1);
      tick();
      dmulti = 1'b0;
      #1;
      chk1("m4_b1_efreeze", efreeze, 1'b1);
      chk1("m4_b1_wpcir", wpcir, 1'b0);
      chk1("m4_b1_dbubble", dbubble, 1'b0);
      chk1("m4_b1_edone", edone, 1'b0);
      chk1("m1_b1_efreeze", efreeze1, 1'b0);
      chk1("m1_b1_wpcir", wpcir1, 1'b1);
      tick();
      chk1("m4_b2_efreeze", efreeze, 1'b1);
      chk1("m4_b2_edone", edone, 1'b0);
      tick();
      chk1("m4_b3_efreeze", efreeze, 1'b1);
      chk1("m4_b3_edone", edone, 1'b1);
      chk1("m4_b3_wpcir", wpcir, 1'b0);
      chk1("m1_b3_edone", edone1, 1'b0);
      tick();
      chk1("m4_end_efreeze", efreeze, 1'b0);
      chk1("m4_end_wpcir", wpcir, 1'b1);
      chk1("m4_end_edone", edone, 1'b0);

      // back-to-back multi-cycle ops
      dmulti = 1'b1;
      tick();
      chk1("b2b_1_efreeze", efreeze, 1'b1);
      tick();
      tick();
      chk1("b2b_1_edone", edone, 1'b1);
      tick();
      chk1("b2b_gap_efreeze", efreeze, 1'b0);
      chk1("b2b_gap_wpcir", wpcir, 1'b1);
      chk1("b2b_gap_dbubble", dbubble, 1'b0);
      tick();
      dmulti = 1'b0;
      #1;
      chk1("b2b_2_efreeze", efreeze, 1'b1);
      chk1("b2b_2_wpcir", wpcir, 1'b0);
      tick();
      tick();
      chk1("b2b_2_edone", edone, 1'b1);
      tick();
      chk1("b2b_2_end", efreeze, 1'b0);

      // flush in the second BUSY cycle
      dmulti = 1'b1;
      tick();
      dmulti = 1'b0;
      #1 chk1("fl_b1_efreeze", efreeze, 1'b1);
      tick();
      eflush = 1'b1;
      #1;
      chk1("fl_b2_efreeze", efreeze, 1'b0);
      chk1("fl_b2_edone", edone, 1'b0);
      chk1("fl_b2_wpcir", wpcir, 1'b0);
      tick();
      eflush = 1'b0;
      #1;
      chk1("fl_idle_efreeze", efreeze, 1'b0);
      chk1("fl_idle_wpcir", wpcir, 1'b1);
      chk1("fl_idle_edone", edone, 1'b0);
      tick();
      chk1("fl_late_edone", edone, 1'b0);
      chk1("fl_late_efreeze", efreeze, 1'b0);

      // flush in IDLE leaves stall logic untouched
      eflush = 1'b1; rs = 5'd2; ern = 5'd2; ewreg = 1'b1; em2reg = 1'b1;
      #1;
      chk1("flidle_wpcir", wpcir, 1'b0);
      chk1("flidle_dbubble", dbubble, 1'b1);
      ern = 5'd0; ewreg = 1'b0; em2reg = 1'b0;
      #1;
      chk1("flidle_free_wpcir", wpcir, 1'b1);
      tick();
      chk1("flidle_efreeze", efreeze, 1'b0);

      // asynchronous reset pulse in the middle of BUSY
      clear();
      dmulti = 1'b1;
      tick();
      dmulti = 1'b0;
      tick();
      chk1("rb_b2_efreeze", efreeze, 1'b1);
      reset = 1'b1;
      rs = 5'd9; ern = 5'd9; ewreg = 1'b1; em2reg = 1'b1;
      #1;
      chk1("rb_efreeze", efreeze, 1'b0);
      chk1("rb_wpcir", wpcir, 1'b1);
      chk1("rb_dbubble", dbubble, 1'b0);
      chk1("rb_edone", edone, 1'b0);
      chk2("rb_fwda", fwda, 2'b00);
      tick();
      chk1("rb_edge_edone", edone, 1'b0);
      reset = 1'b0;
      #1;
      chk1("rb_rel_wpcir", wpcir, 1'b0);
      chk1("rb_rel_dbubble", dbubble, 1'b1);
      chk1("rb_rel_efreeze", efreeze, 1'b0);
      clear();
      tick();
      chk1("rb_idle_efreeze", efreeze, 1'b0);
      chk1("rb_idle_edone", edone, 1'b0);
      chk1("rb_idle_wpcir", wpcir, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_exe_ctrl.md
PIPE_EXE_CTRL -- requirements
Module: pipe_exe_ctrl

Interface
REQ-001 Parameter MULT_LAT, 4, number of cycles a multi-cycle ALU op occupies the E stage; legal range 1..16.
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rs  input  5  ID-stage source register A number.
REQ-005 rt  input  5  ID-stage source register B number.
REQ-006 usert  input  1  ID-stage instruction reads rt.
REQ-007 dmulti  input  1  ID-stage instruction is a multi-cycle ALU op.
REQ-008 ern  input  5  E-stage destination register (already forced to 31 for jal).
REQ-009 ewreg, em2reg  input  1 each  E-stage writes register / result comes from memory.
REQ-010 mrn  input  5  M-stage destination register.
REQ-011 mwreg, mm2reg  input  1 each  M-stage writes register / result comes from memory.
REQ-012 eflush  input  1  abort the instruction in E (taken branch/exception).
REQ-013 fwda, fwdb  output  2 each  operand source select: 00 regfile, 01 E alu, 10 M alu, 11 M memory.
REQ-014 wpcir  output  1  PC and IF/ID write enable; 0 = stall.
REQ-015 dbubble  output  1  ID/E register loads a nop instead of the ID instruction.
REQ-016 efreeze  output  1  E-stage pipeline register holds its contents.
REQ-017 edone  output  1  one-cycle pulse: multi-cycle result valid next cycle.

Function
REQ-018 Forwarding for fwda (rs), priority high to low: ewreg & ~em2reg & ern!=0 & ern==rs -> 01; mwreg & ~mm2reg & mrn!=0 & mrn==rs -> 10; mwreg & mm2reg & mrn!=0 & mrn==rs -> 11; else 00.
REQ-019 fwdb identical to REQ-018 with rt, additionally gated by usert (usert=0 -> 00).
REQ-020 Load-use hazard lu = ewreg & em2reg & ern!=0 & (ern==rs | usert & ern==rt), combinational.
REQ-021 States IDLE and BUSY, plus 4-bit down-counter cnt.
REQ-022 IDLE: efreeze=0; wpcir=~lu; dbubble=lu; edone=0.
REQ-023 IDLE -> BUSY on clock edge when dmulti & ~lu & MULT_LAT>1; cnt loaded with MULT_LAT-1.
REQ-024 BUSY: efreeze=1, wpcir=0, dbubble=0; cnt decrements each edge.
REQ-025 BUSY with cnt==1: edone=1; next edge -> IDLE; the op then spends its final (MULT_LAT-th) cycle in E unfrozen.
REQ-026 MULT_LAT=1: BUSY never entered; multi-cycle op behaves as single-cycle, edone never asserted.
REQ-027 eflush in BUSY: efreeze and edone forced 0 that cycle; next edge -> IDLE, cnt -> 0.
REQ-028 eflush in IDLE: no state change; combinational outputs unaffected.
REQ-029 dmulti with lu in the same cycle: stall first (REQ-022); BUSY entry deferred until lu clears.
REQ-030 Back-to-back multi-cycle ops: the second enters BUSY on the edge leaving its IDLE cycle in ID, no extra bubble.

Reset
REQ-031 reset asserted: state=IDLE, cnt=0 immediately, independent of clock.
REQ-032 While reset asserted: fwda=fwdb=00, wpcir=1, dbubble=0, efreeze=0, edone=0.
REQ-033 Reset during BUSY aborts the op with no edone; first edge after deassertion evaluates from IDLE.

Structure
REQ-034 Shared package holds fwd-select encodings (FWD_REG, FWD_EALU, FWD_MALU, FWD_MMEM) and state encoding.
REQ-035 One sub-module, pipe_fwd_sel, instantiated twice, computes one 2-bit select from (src, use, ern, ewreg, em2reg, mrn, mwreg, mm2reg); FSM and hazard logic stay in the top.

Verification
REQ-036 rs=5, ern=5, ewreg=1, em2reg=0, mrn=5, mwreg=1 -> fwda=01 (E beats M).
REQ-037 rt=3, usert=0, ern=3, ewreg=1, em2reg=1 -> lu=0, wpcir=1, fwdb=00; usert=1 -> wpcir=0, dbubble=1 for one cycle.
REQ-038 MULT_LAT=4, dmulti=1 for one cycle -> efreeze=1, wpcir=0 for exactly 3 cycles, edone in the 3rd, then IDLE.
REQ-039 MULT_LAT=4, eflush in 2nd BUSY cycle -> efreeze=0 that cycle, no edone, IDLE next cycle.
REQ-040 reset pulse mid-BUSY (between edges) -> outputs take reset values at once, no edone, IDLE after release.
REQ-041 ern=0, ewreg=1, em2reg=1, rs=0 -> fwda=00, no stall.
